boot_loader_ctrl: RTL
=====================

Name: boot_loader_ctrl

Overview:
Boot-time controller that owns the single-port program/data RAM before the CPU runs. It holds the CPU (cu, pc) in reset and accepts a stream of 16-bit words over a valid/ready handshake. Each word is written to consecutive RAM addresses starting at a base address. After the last write completes, it hands the RAM port back to the CPU bus path and releases CPU reset. It sits between the external loader interface, the RAM port mux and the CPU reset tree.

Parameters:
DATA_W, 16, RAM word width (instruction = 8-bit opcode + 8-bit operand)
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W words

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled only in IDLE
abort  input  1  cancel an in-progress load
base  input  ADDR_W  first RAM address; latched on start
len  input  ADDR_W+1  number of words to load, legal range 1..DEPTH; latched on start
in_valid  input  1  loader word valid
in_data  input  DATA_W  loader word
in_ready  output  1  controller accepts word this cycle
ram_sel  output  1  1 = loader drives RAM port, 0 = CPU bus drives it
ram_addr  output  ADDR_W  RAM write address (registered)
ram_wdata  output  DATA_W  RAM write data (registered)
ram_we  output  1  RAM write enable (registered)
cpu_rst  output  1  CPU reset hold, active-high
busy  output  1  state is ARM, LOAD or FLUSH
done  output  1  one-cycle pulse on successful completion
err  output  1  sticky error; cleared by the next accepted start
words_loaded  output  ADDR_W+1  beats accepted in current/last load

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, cpu_rst=1, ram_sel=0, ram_we=0, ram_addr=0, ram_wdata=0, in_ready=0, busy=0, done=0, err=0, words_loaded=0. The CPU stays held after reset until a load succeeds.
- States: IDLE, ARM, LOAD, FLUSH, RELEASE.
- IDLE -> ARM: on start with 1<=len<=DEPTH. Latch base and len, clear err and words_loaded, set cpu_rst=1.
- Illegal start (len==0 or len>DEPTH): set err=1 and stay in IDLE. No writes; cpu_rst unchanged.
- Start while busy is ignored.
- ARM (1 cycle): ram_sel=1, in_ready=0 -> LOAD.
- LOAD: in_ready=1 when abort=0 (combinational).
  - A beat is accepted when in_valid && in_ready.
  - Beat accepted in cycle N: in cycle N+1, ram_we=1, ram_addr=(base+k) mod DEPTH (k = beat index from 0), ram_wdata=in_data.
  - One beat per cycle, back-to-back with no bubbles. Gaps in in_valid are allowed.
  - words_loaded increments per beat.
- Address wrap: base+k wraps modulo DEPTH (base=0xFE, len=4 writes FE, FF, 00, 01).
- Last beat: accepted when words_loaded+1==len; the next state is FLUSH, so in_ready drops the cycle after the last beat.
- FLUSH (1 cycle): the last ram_we pulse is issued, ram_sel=1 -> RELEASE.
- RELEASE (1 cycle): done=1, ram_sel=0, cpu_rst=0 (stays 0 afterwards) -> IDLE. The CPU begins its idle->fetch sequence from the following cycle.
- ram_we is 0 in every cycle not immediately following an accepted beat.
- abort in ARM or LOAD:
  - in_ready is forced to 0 that cycle, so no beat is accepted.
  - A write registered from the previous cycle still completes in the abort cycle (ram_sel is still 1).
  - Next state is IDLE with err=1 and cpu_rst=1. done does not pulse.
  - abort in FLUSH, RELEASE or IDLE is ignored.
- rst asserted mid-load: immediate return to reset values on the next edge, including cpu_rst=1. A pending write is dropped.
- A new start in IDLE after a successful load reasserts cpu_rst in ARM (reload/re-boot).

Test Plan:
- Reset: assert rst 2 cycles -> cpu_rst=1, ram_sel=0, ram_we=0, in_ready=0, err=0, done=0.
- Basic load: base=0x00, len=3, words 0x0A05, 0x0B00, 0x0C00 back-to-back -> ram_we on 3 consecutive cycles at addresses 00/01/02 with matching data; FLUSH; done pulse for 1 cycle with cpu_rst=0, ram_sel=0; words_loaded=3.
- Throttled plus wrap: base=0xFE, len=4, in_valid toggling 1,0,1,1,0,1 -> writes at FE, FF, 00, 01 only on the cycles after accepted beats; no write during gaps.
- Illegal length: start with len=0, then with len=257 -> err=1, state stays IDLE, no ram_we, cpu_rst=1; a following legal start clears err.
- Abort: len=5, abort on the cycle after the 2nd beat -> exactly 2 writes, in_ready=0 in the abort cycle, err=1, cpu_rst=1, no done pulse, ram_sel=0 next cycle.
- Start while busy and reset mid-load: start pulsed during LOAD is ignored (base/len unchanged); rst asserted after 1 beat -> pending write suppressed, all outputs at reset values.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: owns the program/data RAM port while the CPU is
// held in reset, streams words from the loader handshake into consecutive
// RAM addresses (wrapping at DEPTH), then hands the port back to the CPU
// bus and releases CPU reset.
module boot_loader_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // DEPTH and the constant one, sized to the word-count width.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LOAD,
    S_FLUSH,
    S_RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                err_q, err_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic                len_legal;
  logic [ADDR_W:0]     words_inc;

  assign len_legal = (len != '0) && (len <= DEPTH);
  assign words_inc = words_q + ONE_W;

  // Next-state, handshake and RAM-write decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    words_d     = words_q;
    err_d       = err_q;
    cpu_rst_d   = cpu_rst_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    in_ready    = 1'b0;
    ram_sel     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_legal) begin
            state_d   = S_ARM;
            base_d    = base;
            len_d     = len;
            words_d   = '0;
            err_d     = 1'b0;
            cpu_rst_d = 1'b1;
          end else begin
            // Bad length: flag it, leave everything else untouched.
            err_d = 1'b1;
          end
        end
      end

      S_ARM: begin
        ram_sel = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          state_d   = S_IDLE;
          err_d     = 1'b1;
          cpu_rst_d = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        ram_sel  = 1'b1;
        busy     = 1'b1;
        in_ready = !abort;
        if (abort) begin
          // The write registered last cycle still lands this cycle.
          state_d   = S_IDLE;
          err_d     = 1'b1;
          cpu_rst_d = 1'b1;
        end else if (in_valid) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = base_q + words_q[ADDR_W-1:0];
          ram_wdata_d = in_data;
          words_d     = words_inc;
          if (words_inc == len_q) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        // Last write is on the port now; CPU reset drops with the hand-back.
        ram_sel   = 1'b1;
        busy      = 1'b1;
        cpu_rst_d = 1'b0;
        state_d   = S_RELEASE;
      end

      S_RELEASE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      words_q     <= '0;
      err_q       <= 1'b0;
      cpu_rst_q   <= 1'b1;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      words_q     <= words_d;
      err_q       <= err_d;
      cpu_rst_q   <= cpu_rst_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule
